pong_match_ctrl: RTL and testbench

PONG_MATCH_CTRL -- requirements
Module: pong_match_ctrl

---
 rtl/pong_match_ctrl.sv | 141 ++++++++++++++
 tb/tb_pong_match_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_match_ctrl.sv
// Match sequencer for a pong game: serve, scoring, ball refill and game-over timing.
// Optional PAUSE state is built only when PONG_PAUSE_EN is defined.
module pong_match_ctrl #(
   parameter int NUM_BALLS     = 3,
   parameter int SCORE_W       = 8,
   parameter int WIN_SCORE     = 10,
   parameter int REFILL_FRAMES = 64,
   parameter int END_FRAMES    = 128,
   parameter bit WIN_CHECK     = 1'b1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               frame_tick,
   input  logic [1:0]         btn,
   input  logic               collided,
   input  logic               missed,
   input  logic               pause,
   output logic               restart,
   output logic               freeze,
   output logic [SCORE_W-1:0] score,
   output logic [3:0]         balls_left,
   output logic [2:0]         state,
   output logic               game_over,
   output logic               win
);

   localparam int TIMER_MAX = (REFILL_FRAMES > END_FRAMES) ? REFILL_FRAMES : END_FRAMES;
   localparam int TIMER_W   = $clog2(TIMER_MAX + 1);

   localparam logic [TIMER_W-1:0] REFILL_LD  = TIMER_W'(REFILL_FRAMES);
   localparam logic [TIMER_W-1:0] END_LD     = TIMER_W'(END_FRAMES);
   localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);
   localparam logic [3:0]         BALLS_INIT = 4'(NUM_BALLS);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_PLAY   = 3'd1,
      S_REFILL = 3'd2,
      S_OVER   = 3'd3,
      S_PAUSE  = 3'd4
   } state_t;

   state_t               state_q, state_d;
   logic [SCORE_W-1:0]   score_q, score_d;
   logic [3:0]           balls_q, balls_d;
   logic [TIMER_W-1:0]   timer_q, timer_d;
   logic                 win_q, win_d;
   logic [SCORE_W-1:0]   score_inc;
   logic                 pause_req;

`ifdef PONG_PAUSE_EN
   assign pause_req = pause;
`else
   assign pause_req = 1'b0;
   wire unused_pause = pause;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         score_q <= '0;
         balls_q <= BALLS_INIT;
         timer_q <= '0;
         win_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         score_q <= score_d;
         balls_q <= balls_d;
         timer_q <= timer_d;
         win_q   <= win_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      score_d   = score_q;
      balls_d   = balls_q;
      win_d     = win_q;
      score_inc = (score_q == '1) ? score_q : score_q + 1'b1;

      case (state_q)
         S_IDLE: begin
            if (btn != 2'b00) begin
               state_d = S_PLAY;
               score_d = '0;
               balls_d = BALLS_INIT;
               win_d   = 1'b0;
            end
         end
         S_PLAY: begin
            // A miss wins over a simultaneous collision: the point is not awarded.
            if (pause_req) begin
               state_d = S_PAUSE;
            end else if (missed) begin
               balls_d = balls_q - 4'd1;
               if (balls_q == 4'd1) begin
                  state_d = S_OVER;
                  win_d   = 1'b0;
               end else begin
                  state_d = S_REFILL;
               end
            end else if (collided) begin
               score_d = score_inc;
               if (WIN_CHECK && (score_inc == WIN_VAL)) begin
                  state_d = S_OVER;
                  win_d   = 1'b1;
               end
            end
         end
         S_REFILL: begin
            if ((timer_q == '0) && (btn != 2'b00)) state_d = S_PLAY;
         end
         S_OVER: begin
            if (timer_q == '0) state_d = S_IDLE;
         end
         S_PAUSE: begin
            if (pause_req) state_d = S_PLAY;
         end
         default: state_d = S_IDLE;
      endcase

      // The load on entry takes precedence, so a tick in that same cycle is lost.
      timer_d = timer_q;
      if ((state_d != state_q) && (state_d == S_REFILL)) begin
         timer_d = REFILL_LD;
      end else if ((state_d != state_q) && (state_d == S_OVER)) begin
         timer_d = END_LD;
      end else if (frame_tick && (timer_q != '0)) begin
         timer_d = timer_q - 1'b1;
      end
   end

   assign state      = state_q;
   assign score      = score_q;
   assign balls_left = balls_q;
   assign win        = win_q;
   assign restart    = (state_q == S_IDLE) || (state_q == S_REFILL) || (state_q == S_OVER);
   assign freeze     = (state_q == S_PAUSE);
   assign game_over  = (state_q == S_OVER);

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Bench for pong_match_ctrl: directed vector table, hand-written timer/win/loss
// sequences, randomized traffic against a reference model, and a saturation instance.
module tb_pong_match_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       frame_tick = 1'b0;
   logic [1:0] btn = 2'b00;
   logic       collided = 1'b0, missed = 1'b0, pause = 1'b0;
   logic       restart, freeze, game_over, win;
   logic [7:0] score;
   logic [3:0] balls_left;
   logic [2:0] state;

   logic       reset2 = 1'b1;
   logic [1:0] btn2 = 2'b00;
   logic       collided2 = 1'b0, missed2 = 1'b0, tick2 = 1'b0, pause2 = 1'b0;
   logic       restart2, freeze2, game_over2, win2;
   logic [3:0] score2;
   logic [3:0] balls2;
   logic [2:0] state2;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   pong_match_ctrl dut (
      .clk(clk), .reset(reset), .frame_tick(frame_tick), .btn(btn),
      .collided(collided), .missed(missed), .pause(pause),
      .restart(restart), .freeze(freeze), .score(score), .balls_left(balls_left),
      .state(state), .game_over(game_over), .win(win)
   );

   pong_match_ctrl #(
      .NUM_BALLS(1), .SCORE_W(4), .WIN_SCORE(15), .WIN_CHECK(1'b0)
   ) dut_sat (
      .clk(clk), .reset(reset2), .frame_tick(tick2), .btn(btn2),
      .collided(collided2), .missed(missed2), .pause(pause2),
      .restart(restart2), .freeze(freeze2), .score(score2), .balls_left(balls2),
      .state(state2), .game_over(game_over2), .win(win2)
   );

   // Reference model of the match rules, kept as plain integers.
   int m_state, m_score, m_balls, m_timer;
   bit m_win;

   task automatic model_step(input bit rst, input logic [1:0] b, input bit col,
                             input bit mis, input bit ft, input bit pse);
      int ns;
      bit pause_on;
`ifdef PONG_PAUSE_EN
      pause_on = 1'b1;
`else
      pause_on = 1'b0;
`endif
      if (rst) begin
         m_state = 0; m_score = 0; m_balls = 3; m_timer = 0; m_win = 0;
         return;
      end
      ns = m_state;
      if (m_state == 0 && b != 0) begin
         ns = 1; m_score = 0; m_balls = 3; m_win = 0;
      end else if (m_state == 1) begin
         if (pause_on && pse) ns = 4;
         else if (mis) begin
            m_balls = m_balls - 1;
            ns = (m_balls == 0) ? 3 : 2;
            if (m_balls == 0) m_win = 0;
         end else if (col) begin
            m_score = (m_score + 1 > 255) ? 255 : m_score + 1;
            if (m_score == 10) begin ns = 3; m_win = 1; end
         end
      end else if (m_state == 2 && m_timer == 0 && b != 0) ns = 1;
      else if (m_state == 3 && m_timer == 0) ns = 0;
      else if (m_state == 4 && pause_on && pse) ns = 1;

      if (ns != m_state && ns == 2)      m_timer = 64;
      else if (ns != m_state && ns == 3) m_timer = 128;
      else if (ft && m_timer > 0)        m_timer = m_timer - 1;
      m_state = ns;
   endtask

   task automatic check_model(input string name);
      logic [18:0] act, exp;
      act = {state, score, balls_left, win, restart, freeze, game_over};
      exp = {3'(m_state), 8'(m_score), 4'(m_balls), m_win,
             (m_state == 0 || m_state == 2 || m_state == 3), (m_state == 4), (m_state == 3)};
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got st=%0d sc=%0d bl=%0d w=%0d rs=%0d fz=%0d go=%0d, want st=%0d sc=%0d bl=%0d w=%0d",
                  name, state, score, balls_left, win, restart, freeze, game_over,
                  m_state, m_score, m_balls, m_win);
      end
   endtask

   task automatic expect_val(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic cycle(input string name, input bit rst, input logic [1:0] b,
                        input bit col, input bit mis, input bit ft, input bit pse);
      reset = rst; btn = b; collided = col; missed = mis; frame_tick = ft; pause = pse;
      model_step(rst, b, col, mis, ft, pse);
      @(posedge clk);
      #1;
      reset = 1'b0; btn = 2'b00; collided = 1'b0; missed = 1'b0; frame_tick = 1'b0; pause = 1'b0;
      check_model(name);
   endtask

   task automatic cycle2(input logic [1:0] b, input bit col, input bit mis);
      btn2 = b; collided2 = col; missed2 = mis;
      @(posedge clk);
      #1;
      btn2 = 2'b00; collided2 = 1'b0; missed2 = 1'b0;
   endtask

   typedef struct {
      bit         rst;
      logic [1:0] b;
      bit         col, mis, ft, pse;
      int         st, sc, bl;
      bit         w;
   } vec_t;

   vec_t vecs[9];

   initial begin
      vecs[0] = '{1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 3, 1'b0};
      vecs[1] = '{1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0, 3, 1'b0};
      vecs[2] = '{1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1, 3, 1'b0};
      vecs[3] = '{1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1, 2, 3, 1'b0};
      vecs[4] = '{1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 2, 2, 2, 1'b0};
      vecs[5] = '{1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 2, 2, 2, 1'b0};
      vecs[6] = '{1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2, 2, 2, 1'b0};
      vecs[7] = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 2, 2, 2, 1'b0};
      vecs[8] = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 2, 2, 2, 1'b0};

      #2;
      for (int i = 0; i < 9; i++) begin
         cycle($sformatf("vec%0d", i), vecs[i].rst, vecs[i].b, vecs[i].col,
               vecs[i].mis, vecs[i].ft, vecs[i].pse);
         expect_val($sformatf("vec%0d_state", i), state, vecs[i].st);
         expect_val($sformatf("vec%0d_score", i), score, vecs[i].sc);
         expect_val($sformatf("vec%0d_balls", i), balls_left, vecs[i].bl);
         expect_val($sformatf("vec%0d_win", i), win, vecs[i].w);
         $display("vec %0d: state=%0d score=%0d balls=%0d win=%0d", i, state, score, balls_left, win);
      end

      // Refill hold: serve button held until the frame timer runs out.
      for (int i = 0; i < 62; i++) cycle("refill_wait", 0, 2'b10, 0, 0, 1, 0);
      expect_val("refill_before_expiry", state, 2);
      cycle("refill_last_tick", 0, 2'b10, 0, 0, 1, 0);
      expect_val("refill_at_zero", state, 2);
      cycle("refill_serve", 0, 2'b10, 0, 0, 0, 0);
      expect_val("refill_to_play", state, 1);
      $display("refill sequence: state=%0d balls=%0d", state, balls_left);

      // Win by reaching the target score.
      for (int i = 0; i < 8; i++) cycle("win_hits", 0, 2'b00, 1, 0, 0, 0);
      expect_val("win_score", score, 10);
      expect_val("win_state", state, 3);
      expect_val("win_flag", win, 1);
      expect_val("win_game_over", game_over, 1);
      $display("win sequence: state=%0d score=%0d win=%0d", state, score, win);

      for (int i = 0; i < 127; i++) cycle("over_wait", 0, 2'b00, 0, 0, 1, 0);
      cycle("over_last_tick", 0, 2'b00, 0, 0, 1, 0);
      expect_val("over_held", state, 3);
      cycle("over_exit", 0, 2'b00, 0, 0, 0, 0);
      expect_val("over_to_idle", state, 0);
      expect_val("idle_score_display", score, 10);
      expect_val("idle_win_display", win, 1);

      // Loss: collision and miss together on the last ball.
      cycle("serve2", 0, 2'b01, 0, 0, 0, 0);
      expect_val("serve2_balls", balls_left, 3);
      cycle("hit", 0, 2'b00, 1, 0, 0, 0);
      cycle("miss1", 0, 2'b00, 0, 1, 0, 0);
      for (int i = 0; i < 64; i++) cycle("refill1", 0, 2'b00, 0, 0, 1, 0);
      cycle("reserve1", 0, 2'b01, 0, 0, 0, 0);
      cycle("miss2_with_tick", 0, 2'b00, 0, 1, 1, 0);
      for (int i = 0; i < 63; i++) cycle("refill2", 0, 2'b01, 0, 0, 1, 0);
      expect_val("load_tick_ignored", state, 2);
      cycle("refill2_end", 0, 2'b01, 0, 0, 1, 0);
      cycle("reserve2", 0, 2'b01, 0, 0, 0, 0);
      expect_val("reserve2_state", state, 1);
      cycle("last_ball", 0, 2'b00, 1, 1, 0, 0);
      expect_val("loss_state", state, 3);
      expect_val("loss_win", win, 0);
      expect_val("loss_score", score, 1);
      for (int i = 0; i < 129; i++) cycle("loss_over", 0, 2'b00, 0, 0, 1, 0);
      expect_val("loss_to_idle", state, 0);
      $display("loss sequence: state=%0d score=%0d win=%0d", state, score, win);

      // Pause behaviour.
      cycle("serve3", 0, 2'b01, 0, 0, 0, 0);
      cycle("pause_on", 0, 2'b00, 0, 0, 0, 1);
`ifdef PONG_PAUSE_EN
      expect_val("pause_state", state, 4);
      expect_val("pause_freeze", freeze, 1);
      cycle("pause_miss", 0, 2'b00, 0, 1, 0, 0);
      expect_val("pause_miss_ignored", balls_left, 3);
      cycle("pause_off", 0, 2'b00, 0, 0, 0, 1);
      expect_val("unpause_state", state, 1);
      expect_val("unpause_balls", balls_left, 3);
`else
      expect_val("pause_ignored_state", state, 1);
      expect_val("pause_ignored_freeze", freeze, 0);
`endif
      $display("pause sequence: state=%0d freeze=%0d balls=%0d", state, freeze, balls_left);

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         cycle("random", ($urandom_range(0, 499) == 0),
               ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
               ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0),
               ($urandom_range(0, 1) == 1), ($urandom_range(0, 31) == 0));
      end
      $display("random phase done: state=%0d score=%0d balls=%0d", state, score, balls_left);

      // Saturating instance: 4-bit score with the win check disabled.
      @(posedge clk);
      #1;
      reset2 = 1'b0;
      expect_val("sat_reset_state", state2, 0);
      expect_val("sat_reset_restart", restart2, 1);
      cycle2(2'b01, 0, 0);
      expect_val("sat_serve", state2, 1);
      for (int i = 0; i < 20; i++) cycle2(2'b00, 1, 0);
      expect_val("sat_score", score2, 15);
      expect_val("sat_still_play", state2, 1);
      cycle2(2'b00, 0, 1);
      expect_val("sat_over", state2, 3);
      #2;
      reset2 = 1'b1;
      #1;
      expect_val("async_reset_state", state2, 0);
      expect_val("async_reset_game_over", game_over2, 0);
      expect_val("async_reset_score", score2, 0);
      expect_val("async_reset_balls", balls2, 1);
      $display("saturation instance: state=%0d score=%0d", state2, score2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
